// File: rtl/ccjiaa_count_pkg.sv
// Shared constants for the two-client counter scheduler: state encoding,
// default width and client count, plus a grant decoder.
package ccjiaa_count_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int NREQ      = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic [NREQ-1:0] client_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ccjiaa_count_core.sv
// Shared WIDTH-bit up-counter datapath: synchronous load beats enable,
// free-running arithmetic wraps modulo 2^WIDTH.
module ccjiaa_count_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (enable) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ccjiaa_count_sched.sv
// Round-robin scheduler granting one of two clients a timed run of the
// shared counter; pulses done on completion or abort on early withdrawal.
module ccjiaa_count_sched
    import ccjiaa_count_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    input  logic             tick,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [1:0]       done,
    output logic             abort,
    output logic [WIDTH-1:0] count
);

    logic [1:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic             abort_q, abort_d;

    logic             winner;
    logic             owner_req;
    logic             last_step;
    logic             terminal;
    logic             core_load;
    logic             core_enable;

    assign winner    = (req[0] & req[1]) ? rr_ptr_q : req[1];
    assign owner_req = req[owner_q];
    assign last_step = ((count + WIDTH'(1)) == len_q);
    assign terminal  = tick & last_step;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        len_d    = len_q;
        abort_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    owner_d = winner;
                    len_d   = winner ? len1 : len0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // A zero-length run is already complete, so it wins over withdrawal.
                if (len_q == '0) begin
                    state_d = ST_DONE;
                end else if (!owner_req) begin
                    state_d  = ST_IDLE;
                    abort_d  = 1'b1;
                    rr_ptr_d = ~owner_q;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (terminal) begin
                    state_d = ST_DONE;
                end else if (!owner_req) begin
                    state_d  = ST_IDLE;
                    abort_d  = 1'b1;
                    rr_ptr_d = ~owner_q;
                end
            end
            default: begin
                rr_ptr_d = ~owner_q;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_comb begin
        gnt_d  = '0;
        done_d = '0;
        if ((state_d == ST_LOAD) || (state_d == ST_RUN)) begin
            gnt_d = client_onehot(owner_d);
        end
        if (state_d == ST_DONE) begin
            done_d = client_onehot(owner_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            len_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            len_q    <= len_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
        end
    end

    // Withholding the step on a withdrawing cycle keeps the count frozen at abort.
    assign core_load   = (state_q == ST_LOAD);
    assign core_enable = (state_q == ST_RUN) & tick & (owner_req | last_step);

    ccjiaa_count_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (core_load),
        .load_value ('0),
        .enable     (core_enable),
        .count      (count)
    );

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign abort = abort_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ccjiaa_count_sched.sv
// Scoreboard bench: stimulus pushes expected done/abort events, a monitor pops
// and compares pulse, count, arrival cycle and grant length.
module tb_ccjiaa_count_sched;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req = 2'b00;
    logic [W-1:0] len0 = '0;
    logic [W-1:0] len1 = '0;
    logic         tick = 1'b1;
    logic [1:0]   gnt;
    logic         busy;
    logic [1:0]   done;
    logic         abort;
    logic [W-1:0] count;

    ccjiaa_count_sched #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .len0  (len0),
        .len1  (len1),
        .tick  (tick),
        .gnt   (gnt),
        .busy  (busy),
        .done  (done),
        .abort (abort),
        .count (count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] done;
        logic       abort;
        int         count;
        int         cyc;
        int         glen;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic push(input logic [1:0] d, input logic a, input int cnt,
                        input int cy, input int gl);
        exp_t e;
        e.done  = d;
        e.abort = a;
        e.count = cnt;
        e.cyc   = cy;
        e.glen  = gl;
        sb.push_back(e);
    endtask

    // Monitor: counts grant cycles and checks every done/abort pulse.
    initial begin
        int   gnt_run;
        exp_t e;
        gnt_run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gnt_run = 0;
            end else begin
                if (gnt != 2'b00) gnt_run++;
                if (done != 2'b00 || abort) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: got done=%b abort=%b expected no pulse (cycle %0d)",
                                 done, abort, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("done", int'(done), int'(e.done));
                        chk("abort", int'(abort), int'(e.abort));
                        chk("count_at_pulse", int'(count), e.count);
                        chk("gnt_at_pulse", int'(gnt), 0);
                        if (e.cyc >= 0) chk("pulse_cycle", cyc, e.cyc);
                        if (e.glen >= 0) chk("gnt_cycles", gnt_run, e.glen);
                        $display("event done=%b abort=%b count=%0d cycle=%0d gnt_cycles=%0d",
                                 done, abort, count, cyc, gnt_run);
                    end
                    gnt_run = 0;
                end
            end
        end
    end

    task automatic wait_evt(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(done != 2'b00 || abort) && n < budget);
        chk({"wait_", name}, int'(done != 2'b00 || abort), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        tick  = 1'b1;
        len0  = '0;
        len1  = '0;
        repeat (2) @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_abort", int'(abort), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;

        // Single client 0, length 3.
        do_reset();
        @(negedge clk);
        len0 = 8'd3; req = 2'b01; c0 = cyc;
        push(2'b01, 1'b0, 3, c0 + 5, 4);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("s1_gnt", int'(gnt), 1);
            chk("s1_count", int'(count), (i == 1) ? 0 : i - 2);
        end
        wait_evt("s1", 10);
        req = 2'b00;
        @(posedge clk); #1;
        chk("s1_busy_after", int'(busy), 0);

        // Both clients from reset: 0, then 1, then 0 again.
        do_reset();
        @(negedge clk);
        len0 = 8'd2; len1 = 8'd5; req = 2'b11; c0 = cyc;
        push(2'b01, 1'b0, 2, c0 + 4, 3);
        push(2'b10, 1'b0, 5, c0 + 12, 6);
        push(2'b01, 1'b0, 2, c0 + 17, 3);
        wait_evt("s2a", 20);
        wait_evt("s2b", 20);
        wait_evt("s2c", 20);
        req = 2'b00;

        // Zero-length run for client 1.
        repeat (2) @(negedge clk);
        len1 = 8'd0; req = 2'b10; c0 = cyc;
        push(2'b10, 1'b0, 0, c0 + 2, 1);
        wait_evt("s3", 10);
        req = 2'b00;

        // Length 4 with tick every third cycle.
        repeat (2) @(negedge clk);
        len0 = 8'd4; req = 2'b01; tick = 1'b0; c0 = cyc;
        push(2'b01, 1'b0, 4, c0 + 14, 13);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done != 2'b00 || abort) break;
            if (cyc == c0 + 4)  chk("s4_count_t0", int'(count), 0);
            if (cyc == c0 + 5)  chk("s4_count_t1", int'(count), 1);
            if (cyc == c0 + 7)  chk("s4_count_hold", int'(count), 1);
            if (cyc == c0 + 8)  chk("s4_count_t2", int'(count), 2);
            if (cyc == c0 + 11) chk("s4_count_t3", int'(count), 3);
            tick = (cyc >= c0 + 2) && (((cyc - c0 - 2) % 3) == 2);
        end
        chk("s4_seen_done", int'(done), 1);
        tick = 1'b1;
        req = 2'b00;

        // Withdrawal at count 4, then client 1 favoured.
        repeat (2) @(negedge clk);
        len0 = 8'd10; req = 2'b01; c0 = cyc;
        push(2'b00, 1'b1, 4, c0 + 7, 6);
        repeat (6) @(negedge clk);
        chk("s5_count_before_drop", int'(count), 4);
        req = 2'b00;
        wait_evt("s5_abort", 5);
        len1 = 8'd1; req = 2'b11; c1 = cyc;
        push(2'b10, 1'b0, 1, c1 + 3, 2);
        wait_evt("s5_next", 10);
        req = 2'b00;

        // Withdrawal on the terminal tick still completes.
        repeat (2) @(negedge clk);
        len0 = 8'd10; req = 2'b01; c0 = cyc;
        push(2'b01, 1'b0, 10, c0 + 12, 11);
        repeat (11) @(negedge clk);
        chk("s6_count_before_drop", int'(count), 9);
        req = 2'b00;
        wait_evt("s6", 5);

        // Reset mid-run at count 6, then a fresh request.
        repeat (2) @(negedge clk);
        len0 = 8'd10; req = 2'b01; c0 = cyc;
        repeat (8) @(negedge clk);
        chk("s7_count_before_rst", int'(count), 6);
        rst_n = 1'b0;
        req = 2'b00;
        #1;
        chk("s7_rst_count", int'(count), 0);
        chk("s7_rst_gnt", int'(gnt), 0);
        chk("s7_rst_busy", int'(busy), 0);
        chk("s7_rst_done", int'(done), 0);
        chk("s7_rst_abort", int'(abort), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        len0 = 8'd3; req = 2'b01; c0 = cyc;
        push(2'b01, 1'b0, 3, c0 + 5, 4);
        wait_evt("s7_fresh", 10);
        req = 2'b00;

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
